// File: rtl/arf.sv
// Architectural register file: committed data plus busy/RRF-tag rename status per register.
// Optional ARF_WRITE_BYPASS_EN forwards the same-cycle commit to the read ports.
module arf_entry #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                we_i,
  input  logic                set_i,
  input  logic                clr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [RRF_SEL-1:0]  stag_i,
  output logic [DATA_LEN-1:0] data_o,
  output logic                busy_o,
  output logic [RRF_SEL-1:0]  tag_o
);
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_o <= '0;
      busy_o <= 1'b0;
      tag_o  <= '0;
    end else begin
      if (we_i) data_o <= wdata_i;
      // set-busy outranks a same-cycle clear; the caller already masks clr with set
      if (set_i) begin
        busy_o <= 1'b1;
        tag_o  <= stag_i;
      end else if (clr_i) begin
        busy_o <= 1'b0;
      end
    end
  end
endmodule

module arf #(
  parameter int DATA_LEN = 32,
  parameter int REG_SEL  = 5,
  parameter int RRF_SEL  = 6
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [REG_SEL-1:0]  rs1_i,
  input  logic [REG_SEL-1:0]  rs2_i,
  output logic [DATA_LEN-1:0] rs1_arf_data_o,
  output logic [DATA_LEN-1:0] rs2_arf_data_o,
  output logic                rs1_arf_busy_o,
  output logic                rs2_arf_busy_o,
  output logic [RRF_SEL-1:0]  rs1_arf_rrftag_o,
  output logic [RRF_SEL-1:0]  rs2_arf_rrftag_o,
  input  logic [REG_SEL-1:0]  completed_dst_num_i,
  input  logic [DATA_LEN-1:0] from_rrfdata_i,
  input  logic [RRF_SEL-1:0]  completed_dst_rrftag_i,
  input  logic                completed_we_i,
  input  logic [REG_SEL-1:0]  dst_num_setbusy_i,
  input  logic [RRF_SEL-1:0]  dst_rrftag_setbusy_i,
  input  logic                dst_en_setbusy_i
);
  localparam int REG_NUM = 2**REG_SEL;

  logic [REG_NUM-1:0]               we_dec, set_dec, clr_dec;
  logic [REG_NUM-1:0][DATA_LEN-1:0] rf_data;
  logic [REG_NUM-1:0]               rf_busy;
  logic [REG_NUM-1:0][RRF_SEL-1:0]  rf_tag;

  // index 0 never decodes, so entry 0 stays at its reset value of all zeros
  assign we_dec  = (completed_we_i && completed_dst_num_i != '0)
                   ? (REG_NUM'(1) << completed_dst_num_i) : '0;
  assign set_dec = (dst_en_setbusy_i && dst_num_setbusy_i != '0)
                   ? (REG_NUM'(1) << dst_num_setbusy_i) : '0;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
    assign clr_dec[g] = we_dec[g] & (rf_tag[g] == completed_dst_rrftag_i) & ~set_dec[g];

    arf_entry #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL)) u_entry (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .we_i    (we_dec[g]),
      .set_i   (set_dec[g]),
      .clr_i   (clr_dec[g]),
      .wdata_i (from_rrfdata_i),
      .stag_i  (dst_rrftag_setbusy_i),
      .data_o  (rf_data[g]),
      .busy_o  (rf_busy[g]),
      .tag_o   (rf_tag[g])
    );
  end

  always_comb begin
    rs1_arf_data_o   = rf_data[rs1_i];
    rs1_arf_busy_o   = rf_busy[rs1_i];
    rs1_arf_rrftag_o = rf_tag[rs1_i];
    rs2_arf_data_o   = rf_data[rs2_i];
    rs2_arf_busy_o   = rf_busy[rs2_i];
    rs2_arf_rrftag_o = rf_tag[rs2_i];
`ifdef ARF_WRITE_BYPASS_EN
    if (we_dec[rs1_i]) begin
      rs1_arf_data_o = from_rrfdata_i;
      rs1_arf_busy_o = rf_busy[rs1_i] & ~clr_dec[rs1_i];
    end
    if (we_dec[rs2_i]) begin
      rs2_arf_data_o = from_rrfdata_i;
      rs2_arf_busy_o = rf_busy[rs2_i] & ~clr_dec[rs2_i];
    end
`endif
  end
endmodule

// File: tb/tb_arf.sv
// Bench for arf: directed vector table, async reset and bypass sequences, random vs model.
module tb_arf;
  localparam int DL = 32, RS = 5, TS = 6, RN = 32;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [RS-1:0] rs1_i, rs2_i;
  logic [DL-1:0] rs1_arf_data_o, rs2_arf_data_o;
  logic          rs1_arf_busy_o, rs2_arf_busy_o;
  logic [TS-1:0] rs1_arf_rrftag_o, rs2_arf_rrftag_o;
  logic [RS-1:0] completed_dst_num_i;
  logic [DL-1:0] from_rrfdata_i;
  logic [TS-1:0] completed_dst_rrftag_i;
  logic          completed_we_i;
  logic [RS-1:0] dst_num_setbusy_i;
  logic [TS-1:0] dst_rrftag_setbusy_i;
  logic          dst_en_setbusy_i;

  arf dut (
    .clk_i(clk_i), .reset_i(reset_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_arf_data_o(rs1_arf_data_o), .rs2_arf_data_o(rs2_arf_data_o),
    .rs1_arf_busy_o(rs1_arf_busy_o), .rs2_arf_busy_o(rs2_arf_busy_o),
    .rs1_arf_rrftag_o(rs1_arf_rrftag_o), .rs2_arf_rrftag_o(rs2_arf_rrftag_o),
    .completed_dst_num_i(completed_dst_num_i), .from_rrfdata_i(from_rrfdata_i),
    .completed_dst_rrftag_i(completed_dst_rrftag_i), .completed_we_i(completed_we_i),
    .dst_num_setbusy_i(dst_num_setbusy_i), .dst_rrftag_setbusy_i(dst_rrftag_setbusy_i),
    .dst_en_setbusy_i(dst_en_setbusy_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reads(input string nm,
                           input logic [DL-1:0] d1, input logic b1, input logic [TS-1:0] t1,
                           input logic [DL-1:0] d2, input logic b2, input logic [TS-1:0] t2);
    chk({nm, " rs1 data"}, rs1_arf_data_o, d1);
    chk({nm, " rs1 busy"}, 32'(rs1_arf_busy_o), 32'(b1));
    chk({nm, " rs1 tag"},  32'(rs1_arf_rrftag_o), 32'(t1));
    chk({nm, " rs2 data"}, rs2_arf_data_o, d2);
    chk({nm, " rs2 busy"}, 32'(rs2_arf_busy_o), 32'(b2));
    chk({nm, " rs2 tag"},  32'(rs2_arf_rrftag_o), 32'(t2));
  endtask

  task automatic idle();
    completed_we_i = 0; completed_dst_num_i = 0; from_rrfdata_i = 0; completed_dst_rrftag_i = 0;
    dst_en_setbusy_i = 0; dst_num_setbusy_i = 0; dst_rrftag_setbusy_i = 0;
  endtask

  // Directed vectors: inputs applied before an edge; expected reads are pre-edge state.
  typedef struct {
    logic [RS-1:0] rs1, rs2;
    logic cwe; logic [RS-1:0] cdst; logic [DL-1:0] cdata; logic [TS-1:0] ctag;
    logic sen; logic [RS-1:0] sdst; logic [TS-1:0] stag;
    logic [DL-1:0] d1; logic b1; logic [TS-1:0] t1;
    logic [DL-1:0] d2; logic b2; logic [TS-1:0] t2;
  } vec_t;
  vec_t vecs[10];

  // Reference model: spec rules applied directly to plain arrays.
  logic [DL-1:0] m_data[RN];
  logic          m_busy[RN];
  logic [TS-1:0] m_tag[RN];

  task automatic m_reset();
    for (int i = 0; i < RN; i++) begin m_data[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
  endtask

  task automatic m_read(input int idx, output logic [DL-1:0] d, output logic b, output logic [TS-1:0] t);
    d = m_data[idx]; b = m_busy[idx]; t = m_tag[idx];
    if (idx == 0) begin d = 0; b = 0; t = 0; end
`ifdef ARF_WRITE_BYPASS_EN
    else if (completed_we_i && int'(completed_dst_num_i) == idx) begin
      d = from_rrfdata_i;
      if (m_tag[idx] == completed_dst_rrftag_i && !(dst_en_setbusy_i && int'(dst_num_setbusy_i) == idx))
        b = 0;
    end
`endif
  endtask

  task automatic m_edge();
    int cd = int'(completed_dst_num_i), sd = int'(dst_num_setbusy_i);
    bit hit = dst_en_setbusy_i && sd == cd;
    if (completed_we_i && cd != 0) begin
      m_data[cd] = from_rrfdata_i;
      if (m_tag[cd] == completed_dst_rrftag_i && !hit) m_busy[cd] = 0;
    end
    if (dst_en_setbusy_i && sd != 0) begin m_busy[sd] = 1; m_tag[sd] = dst_rrftag_setbusy_i; end
  endtask

  initial begin
    logic [DL-1:0] d1, d2; logic b1, b2; logic [TS-1:0] t1, t2;
    //          rs1 rs2 cwe cdst cdata ctag sen sdst stag  d1 b1 t1  d2 b2 t2
    vecs[0] = '{0, 0, 0, 0, 0,  0,  1, 1, 12, 0,  0, 0,  0,  0, 0};
    vecs[1] = '{1, 1, 0, 0, 0,  0,  1, 2, 13, 0,  1, 12, 0,  1, 12};
    vecs[2] = '{2, 2, 1, 1, 14, 12, 0, 0, 0,  0,  1, 13, 0,  1, 13};
    vecs[3] = '{1, 3, 1, 2, 15, 13, 1, 2, 13, 14, 0, 12, 0,  0, 0};
    vecs[4] = '{1, 0, 1, 2, 16, 12, 0, 0, 0,  14, 0, 12, 0,  0, 0};
    vecs[5] = '{2, 2, 0, 0, 0,  0,  1, 3, 5,  16, 1, 13, 16, 1, 13};
    vecs[6] = '{2, 1, 1, 3, 7,  4,  0, 0, 0,  16, 1, 13, 14, 0, 12};
    vecs[7] = '{3, 3, 1, 0, 99, 0,  1, 0, 9,  7,  1, 5,  7,  1, 5};
    vecs[8] = '{0, 3, 0, 0, 0,  0,  0, 0, 0,  0,  0, 0,  7,  1, 5};
    vecs[9] = '{0, 0, 0, 0, 0,  0,  0, 0, 0,  0,  0, 0,  0,  0, 0};

    idle(); rs1_i = 1; rs2_i = 2; reset_i = 0;
    #3 chk_reads("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); reset_i = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      rs1_i = vecs[i].rs1; rs2_i = vecs[i].rs2;
      completed_we_i = vecs[i].cwe; completed_dst_num_i = vecs[i].cdst;
      from_rrfdata_i = vecs[i].cdata; completed_dst_rrftag_i = vecs[i].ctag;
      dst_en_setbusy_i = vecs[i].sen; dst_num_setbusy_i = vecs[i].sdst;
      dst_rrftag_setbusy_i = vecs[i].stag;
      #1 chk_reads($sformatf("vec%0d", i), vecs[i].d1, vecs[i].b1, vecs[i].t1,
                   vecs[i].d2, vecs[i].b2, vecs[i].t2);
    end

    // Bypass: r4 busy with tag 20, then a matching commit read in the same cycle.
    @(negedge clk_i); idle(); dst_en_setbusy_i = 1; dst_num_setbusy_i = 4; dst_rrftag_setbusy_i = 20;
    @(negedge clk_i); idle(); rs1_i = 4; rs2_i = 3;
    completed_we_i = 1; completed_dst_num_i = 4; from_rrfdata_i = 32'hABCD; completed_dst_rrftag_i = 20;
    #1;
`ifdef ARF_WRITE_BYPASS_EN
    chk_reads("bypass", 32'hABCD, 0, 20, 7, 1, 5);
`else
    chk_reads("nobypass", 0, 1, 20, 7, 1, 5);
`endif

    // Async reset mid-cycle, away from any clock edge.
    @(negedge clk_i); idle(); rs1_i = 4; rs2_i = 3;
    #2 reset_i = 0;
    #1 chk_reads("async reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); reset_i = 1;
    m_reset();

    // Random phase: narrow index/tag ranges to force collisions and tag matches.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      rs1_i = RS'($urandom_range(0, 7)); rs2_i = RS'($urandom_range(0, 7));
      completed_we_i = 1'($urandom_range(0, 1));
      completed_dst_num_i = RS'($urandom_range(0, 7));
      from_rrfdata_i = $urandom;
      completed_dst_rrftag_i = TS'($urandom_range(0, 3));
      dst_en_setbusy_i = 1'($urandom_range(0, 1));
      dst_num_setbusy_i = RS'($urandom_range(0, 7));
      dst_rrftag_setbusy_i = TS'($urandom_range(0, 3));
      #1;
      m_read(int'(rs1_i), d1, b1, t1);
      m_read(int'(rs2_i), d2, b2, t2);
      chk_reads($sformatf("rand%0d", c), d1, b1, t1, d2, b2, t2);
      @(posedge clk_i);
      m_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
